// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream s2c register slice.
//   DATA_W_DEF / KEEP_W_DEF / CNT_W_DEF : default widths
//   slice_state_e                       : occupancy of the OUT/SKID pair
package axis_pkg;

  localparam int unsigned DATA_W_DEF = 256;
  localparam int unsigned KEEP_W_DEF = DATA_W_DEF / 8;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } slice_state_e;

endpackage

// File: rtl/axis_s2c_slice_if.sv
// Handshake/bus bundle for axis_s2c_slice.
//   *_s2c signals : upstream beat into the slice
//   axis_t*       : downstream beat out of the slice
//   slave modport : the slice's view; master modport: the surrounding logic.
interface axis_s2c_slice_if
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned KEEP_W = KEEP_W_DEF
) ();

  logic [DATA_W-1:0] axis_tdata_s2c;
  logic [KEEP_W-1:0] axis_tkeep_s2c;
  logic              axis_tlast_s2c;
  logic              axis_tvalid_s2c;
  logic              axis_tready_s2c;

  logic [DATA_W-1:0] axis_tdata;
  logic [KEEP_W-1:0] axis_tkeep;
  logic              axis_tlast;
  logic              axis_tvalid;
  logic              axis_tready;

  modport slave (
    input  axis_tdata_s2c, axis_tkeep_s2c, axis_tlast_s2c, axis_tvalid_s2c,
    output axis_tready_s2c,
    output axis_tdata, axis_tkeep, axis_tlast, axis_tvalid,
    input  axis_tready
  );

  modport master (
    output axis_tdata_s2c, axis_tkeep_s2c, axis_tlast_s2c, axis_tvalid_s2c,
    input  axis_tready_s2c,
    input  axis_tdata, axis_tkeep, axis_tlast, axis_tvalid,
    output axis_tready
  );

endinterface

// File: rtl/axis_s2c_slice_popcount.sv
// keep_popcount: purely combinational count of set bits in a byte-enable word.
//   keep    : byte enables (KEEP_W)
//   count_c : number of set bits ($clog2(KEEP_W)+1)
module keep_popcount #(
  parameter int unsigned KEEP_W = 32
) (
  input  logic [KEEP_W-1:0]      keep,
  output logic [$clog2(KEEP_W):0] count_c
);

  localparam int unsigned PC_W = $clog2(KEEP_W) + 1;

  always_comb begin
    count_c = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      count_c = count_c + PC_W'(keep[i]);
    end
  end

endmodule

// File: rtl/axis_s2c_slice.sv
// Full-throughput AXI-Stream register slice (OUT + SKID) with per-frame
// byte accounting on the downstream side.
//   aclk, aresetn : clock, synchronous active-low reset
//   bus           : upstream (*_s2c) and downstream (axis_t*) handshake bundle
//   frame_bytes   : saturated byte count of the last completed frame
//   frame_done    : one-cycle pulse when frame_bytes updates
//   frame_ovf     : that frame exceeded the counter range (valid with frame_done)
module axis_s2c_slice
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned KEEP_W = KEEP_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             aclk,
  input  logic             aresetn,
  axis_s2c_slice_if.slave  bus,
  output logic [CNT_W-1:0] frame_bytes,
  output logic             frame_done,
  output logic             frame_ovf
);

  localparam int unsigned BEAT_W = DATA_W + KEEP_W + 1;
  localparam int unsigned PC_W   = $clog2(KEEP_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slice_state_e      state_q, state_d;
  logic              tready_q, tvalid_q;
  logic [BEAT_W-1:0] out_q, skid_q, in_beat;
  logic              in_acc, out_acc;
  logic              load_out_in, load_out_skid, load_skid;

  logic [CNT_W-1:0]  acc_q, acc_next;
  logic              sat_q, sat_now;
  logic [CNT_W:0]    sum;
  logic [PC_W-1:0]   out_pc;

  assign in_beat = {bus.axis_tdata_s2c, bus.axis_tkeep_s2c, bus.axis_tlast_s2c};
  assign in_acc  = bus.axis_tvalid_s2c & tready_q;
  assign out_acc = tvalid_q & bus.axis_tready;

  assign bus.axis_tready_s2c = tready_q;
  assign bus.axis_tvalid     = tvalid_q;
  assign bus.axis_tdata      = out_q[BEAT_W-1 -: DATA_W];
  assign bus.axis_tkeep      = out_q[KEEP_W:1];
  assign bus.axis_tlast      = out_q[0];

  // State register; ready/valid are registered copies of the next occupancy.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= EMPTY;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= (state_d != FULL);
      tvalid_q <= (state_d != EMPTY);
    end
  end

  // Next-state and load selects.
  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_acc) begin
          load_out_in = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (in_acc && out_acc) begin
          load_out_in = 1'b1;
        end else if (in_acc) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_acc) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_acc) begin
          load_out_skid = 1'b1;
          state_d       = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Beat storage.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_in) begin
        out_q <= in_beat;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_beat;
      end
    end
  end

  keep_popcount #(.KEEP_W(KEEP_W)) u_popcount (
    .keep    (out_q[KEEP_W:1]),
    .count_c (out_pc)
  );

  // Saturating add; one extra bit catches the wrap.
  assign sum      = (CNT_W+1)'(acc_q) + (CNT_W+1)'(out_pc);
  assign sat_now  = (sum > {1'b0, CNT_MAX});
  assign acc_next = sat_now ? CNT_MAX : sum[CNT_W-1:0];

  // Frame byte accounting on downstream accepts.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc_q       <= '0;
      sat_q       <= 1'b0;
      frame_bytes <= '0;
      frame_done  <= 1'b0;
      frame_ovf   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_acc) begin
        if (out_q[0]) begin
          frame_bytes <= acc_next;
          frame_ovf   <= sat_q | sat_now;
          frame_done  <= 1'b1;
          acc_q       <= '0;
          sat_q       <= 1'b0;
        end else begin
          acc_q <= acc_next;
          sat_q <= sat_q | sat_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_s2c_slice.sv
// Self-checking bench for axis_s2c_slice (CNT_W=8 to reach saturation).
module tb_axis_s2c_slice;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned KEEP_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BEAT_W = DATA_W + KEEP_W + 1;
  localparam int          MAXB   = 255;

  logic             clk = 1'b0;
  logic             aresetn;
  logic [CNT_W-1:0] frame_bytes;
  logic             frame_done;
  logic             frame_ovf;
  int               cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  axis_s2c_slice_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) bus ();

  axis_s2c_slice #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .CNT_W(CNT_W)) dut (
    .aclk        (clk),
    .aresetn     (aresetn),
    .bus         (bus),
    .frame_bytes (frame_bytes),
    .frame_done  (frame_done),
    .frame_ovf   (frame_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: accepted beats in order, plain unbounded byte sum per frame.
  logic [BEAT_W-1:0] sb[$];
  int                frame_sum = 0;
  logic              exp_done = 1'b0;
  int                exp_bytes = 0;
  logic              exp_ovf = 1'b0;
  logic              prev_hold = 1'b0;
  logic [BEAT_W-1:0] prev_beat = '0;

  always @(negedge clk) begin
    logic [BEAT_W-1:0] got, exp;
    logic              done_next;
    if (!aresetn) begin
      sb.delete();
      frame_sum = 0;
      exp_done  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      done_next = 1'b0;
      got = {bus.axis_tdata, bus.axis_tkeep, bus.axis_tlast};
      check_eq("frame_done", frame_done, exp_done);
      if (exp_done) begin
        check_eq("frame_bytes", frame_bytes, exp_bytes);
        check_eq("frame_ovf", frame_ovf, exp_ovf);
      end
      check_eq("no_x", $isunknown({got, bus.axis_tvalid, bus.axis_tready_s2c}), 0);
      if (prev_hold) begin
        check_eq("hold_valid", bus.axis_tvalid, 1);
        check_eq("hold_beat", got, prev_beat);
      end
      if (bus.axis_tvalid && bus.axis_tready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          exp = sb.pop_front();
          check_eq("beat", got, exp);
        end
        frame_sum += $countones(bus.axis_tkeep);
        if (bus.axis_tlast) begin
          exp_bytes = (frame_sum > MAXB) ? MAXB : frame_sum;
          exp_ovf   = (frame_sum > MAXB);
          done_next = 1'b1;
          frame_sum = 0;
        end
      end
      prev_hold = bus.axis_tvalid && !bus.axis_tready;
      prev_beat = got;
      if (bus.axis_tvalid_s2c && bus.axis_tready_s2c)
        sb.push_back({bus.axis_tdata_s2c, bus.axis_tkeep_s2c, bus.axis_tlast_s2c});
      exp_done = done_next;
    end
  end

  // Offer one beat from the posedge+1 phase; returns in that phase after acceptance.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k, input logic l);
    int   n = 0;
    logic acc = 1'b0;
    bus.axis_tdata_s2c  = d;
    bus.axis_tkeep_s2c  = k;
    bus.axis_tlast_s2c  = l;
    bus.axis_tvalid_s2c = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.axis_tvalid_s2c & bus.axis_tready_s2c;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check_eq("send_timeout", 0, 1);
    bus.axis_tvalid_s2c = 1'b0;
    bus.axis_tdata_s2c  = rnd_data();
    bus.axis_tkeep_s2c  = $urandom;
    bus.axis_tlast_s2c  = 1'($urandom);
  endtask

  // Wait for a frame_done pulse, sampled at negedge; reports the cycle seen.
  task automatic wait_done(output int at_cyc);
    int n = 0;
    at_cyc = -1;
    while (n < 100) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        at_cyc = cyc;
        break;
      end
      n++;
    end
    if (at_cyc < 0) check_eq("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int c0, dc;
    logic [DATA_W-1:0] b0;
    logic acc;
    int sent, guard;

    aresetn = 1'b0;
    bus.axis_tdata_s2c  = '0;
    bus.axis_tkeep_s2c  = '0;
    bus.axis_tlast_s2c  = 1'b0;
    bus.axis_tvalid_s2c = 1'b0;
    bus.axis_tready     = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outs", {bus.axis_tready_s2c, bus.axis_tvalid, bus.axis_tdata, bus.axis_tkeep,
                          bus.axis_tlast, frame_bytes, frame_done, frame_ovf}, 0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    check_eq("ready_before_edge", bus.axis_tready_s2c, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("ready_after_edge", bus.axis_tready_s2c, 1);
    @(posedge clk); #1;

    // 4-beat back-to-back full-keep frame.
    bus.axis_tready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 4; i++) send_beat(rnd_data(), '1, i == 3);
    check_eq("b2b_in_cycles", cyc - c0, 4);
    wait_done(dc);
    check_eq("b2b_done_cycle", dc - c0, 5);
    check_eq("b2b_bytes", frame_bytes, 128);

    // Single short beat.
    c0 = cyc;
    send_beat(rnd_data(), 32'h0000_000F, 1'b1);
    wait_done(dc);
    check_eq("single_done_cycle", dc - c0, 2);
    check_eq("single_bytes", frame_bytes, 4);
    check_eq("single_ovf", frame_ovf, 0);

    // Stall: two beats fill OUT+SKID, third waits until drain.
    bus.axis_tready = 1'b0;
    b0 = rnd_data();
    fork
      begin
        send_beat(b0, '1, 1'b0);
        send_beat(rnd_data(), '1, 1'b0);
        send_beat(rnd_data(), '1, 1'b1);
      end
      begin
        repeat (6) @(negedge clk);
        check_eq("stall_ready_low", bus.axis_tready_s2c, 0);
        check_eq("stall_valid", bus.axis_tvalid, 1);
        check_eq("stall_data_b0", bus.axis_tdata, b0);
        @(posedge clk); #1;
        bus.axis_tready = 1'b1;
      end
    join
    wait_done(dc);
    check_eq("stall_bytes", frame_bytes, 96);

    // Random valid/ready over 1000 beats.
    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      if (!bus.axis_tvalid_s2c) begin
        bus.axis_tdata_s2c = rnd_data();
        bus.axis_tkeep_s2c = ($urandom_range(0, 3) == 0) ? '1 : KEEP_W'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          bus.axis_tvalid_s2c = 1'b1;
          bus.axis_tlast_s2c  = (sent == 999) || ($urandom_range(0, 5) == 0);
        end else begin
          bus.axis_tlast_s2c  = 1'($urandom);
        end
      end
      bus.axis_tready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = bus.axis_tvalid_s2c & bus.axis_tready_s2c;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        sent++;
        bus.axis_tvalid_s2c = 1'b0;
      end
    end
    check_eq("rand_sent", sent, 1000);
    bus.axis_tvalid_s2c = 1'b0;
    bus.axis_tready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    check_eq("rand_drained", sb.size(), 0);
    repeat (2) @(posedge clk); #1;

    // Saturating 9-beat frame, then a fresh 1-beat frame.
    for (int i = 0; i < 9; i++) send_beat(rnd_data(), '1, i == 8);
    wait_done(dc);
    check_eq("sat_bytes", frame_bytes, 255);
    check_eq("sat_ovf", frame_ovf, 1);
    send_beat(rnd_data(), '1, 1'b1);
    wait_done(dc);
    check_eq("post_sat_bytes", frame_bytes, 32);
    check_eq("post_sat_ovf", frame_ovf, 0);

    // Reset while FULL mid-frame.
    send_beat(rnd_data(), '1, 1'b0);
    @(posedge clk); #1;
    bus.axis_tready = 1'b0;
    send_beat(rnd_data(), '1, 1'b0);
    send_beat(rnd_data(), '1, 1'b0);
    @(negedge clk);
    check_eq("full_before_rst", bus.axis_tready_s2c, 0);
    @(posedge clk); #1;
    aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    check_eq("midrst_outs", {bus.axis_tready_s2c, bus.axis_tvalid, bus.axis_tdata, bus.axis_tkeep,
                             bus.axis_tlast, frame_bytes, frame_done, frame_ovf}, 0);
    @(posedge clk); #1;
    bus.axis_tready = 1'b1;
    send_beat(rnd_data(), 32'h0000_0003, 1'b1);
    wait_done(dc);
    check_eq("midrst_new_bytes", frame_bytes, 2);
    check_eq("midrst_new_ovf", frame_ovf, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_s2c_slice.md
AXIS_S2C_SLICE -- requirements
Module: axis_s2c_slice

Interface
REQ-001 Parameter DATA_W, 256, stream data width in bits.
REQ-002 Parameter KEEP_W, 32, byte-enable width (DATA_W/8).
REQ-003 Parameter CNT_W, 16, frame byte-counter width.
REQ-004 aclk  in  1  sole clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, synchronous, active-low.
REQ-006 axis_tdata_s2c  in  DATA_W  upstream beat data.
REQ-007 axis_tkeep_s2c  in  KEEP_W  upstream byte enables.
REQ-008 axis_tlast_s2c  in  1  upstream last beat of frame.
REQ-009 axis_tvalid_s2c  in  1  upstream beat valid.
REQ-010 axis_tready_s2c  out  1  slice can accept a beat; driven from a register.
REQ-011 axis_tdata  out  DATA_W  downstream beat data.
REQ-012 axis_tkeep  out  KEEP_W  downstream byte enables.
REQ-013 axis_tlast  out  1  downstream last beat.
REQ-014 axis_tvalid  out  1  downstream beat valid.
REQ-015 axis_tready  in  1  downstream accepts beat.
REQ-016 frame_bytes  out  CNT_W  byte count of the most recently completed frame.
REQ-017 frame_done  out  1  one-cycle pulse when frame_bytes updates.
REQ-018 frame_ovf  out  1  completed frame exceeded 2^CNT_W-1 bytes; qualified by frame_done.

Function
REQ-019 In-accept = axis_tvalid_s2c & axis_tready_s2c; out-accept = axis_tvalid & axis_tready.
REQ-020 Storage: output register (OUT) plus one skid register (SKID), each holding {data, keep, last}.
REQ-021 States: EMPTY (nothing held), BUSY (OUT valid), FULL (OUT and SKID valid).
REQ-022 EMPTY: in-accept -> load OUT, go BUSY; otherwise stay.
REQ-023 BUSY: in-accept & out-accept -> load OUT from input, stay BUSY.
REQ-024 BUSY: in-accept & no out-accept -> load SKID, go FULL.
REQ-025 BUSY: out-accept & no in-accept -> go EMPTY.
REQ-026 FULL: out-accept -> copy SKID into OUT, go BUSY; otherwise stay.
REQ-027 axis_tready_s2c = 1 in EMPTY and BUSY, 0 in FULL; it is updated on the same edge as the state.
REQ-028 axis_tvalid = 1 in BUSY and FULL.
REQ-029 Latency: beat accepted at edge N appears on the outputs after edge N (zero bubbles).
REQ-030 Throughput: sustained one beat per cycle when axis_tready is held high.
REQ-031 While axis_tvalid=1 and axis_tready=0, axis_tdata, axis_tkeep and axis_tlast hold stable.
REQ-032 Beat order is preserved; no beat is duplicated or dropped.
REQ-033 Input data/keep/last are ignored when axis_tvalid_s2c=0.
REQ-034 Byte accounting occurs on out-accept: the accumulator adds popcount(axis_tkeep), saturating at 2^CNT_W-1.
REQ-035 Keep bits are counted as-is; non-contiguous keep patterns are not rejected.
REQ-036 Out-accept with axis_tlast=1: frame_bytes <= accumulator + popcount (saturated), frame_ovf <= saturation-occurred flag, frame_done=1 for one cycle, accumulator and flag cleared.
REQ-037 A frame end and the first beat of the next frame never share a beat; the beat after a last beat starts at accumulator 0.
REQ-038 frame_done is 0 in all cycles without a last-beat out-accept.

Reset
REQ-039 When aresetn=0 at an edge: state EMPTY, axis_tready_s2c=0, axis_tvalid=0, axis_tdata=0, axis_tkeep=0, axis_tlast=0.
REQ-040 When aresetn=0 at an edge: accumulator=0, frame_bytes=0, frame_done=0, frame_ovf=0.
REQ-041 axis_tready_s2c goes to 1 at the first edge with aresetn=1.
REQ-042 Reset mid-frame discards OUT, SKID and the partial count, with no frame_done pulse.

Structure
REQ-043 Shared package axis_pkg holds DATA_W/KEEP_W defaults and the slice state enum {EMPTY, BUSY, FULL}.
REQ-044 One sub-module, keep_popcount, is purely combinational: KEEP_W in, $clog2(KEEP_W)+1 out.

Verification
REQ-045 Reset release, axis_tready=1, 4-beat frame with all-ones keep, back-to-back -> 4 output beats on consecutive cycles, frame_bytes=128, one frame_done pulse.
REQ-046 axis_tready=0 while 3 beats are offered -> 2 beats are accepted, axis_tready_s2c drops to 0, output holds beat 0 stable; axis_tready=1 -> beats 0 and 1 drain in order, then beat 2 is accepted.
REQ-047 Random valid/ready toggling over 1000 beats -> output sequence identical to input, no X, and held outputs are stable under stall.
REQ-048 Single-beat frame with keep=0x0000000F and tlast=1 -> frame_bytes=4 and frame_done in the cycle after out-accept.
REQ-049 With CNT_W=8, a 9-beat all-ones-keep frame -> frame_bytes=255 and frame_ovf=1; the next 1-beat frame -> frame_bytes=32 and frame_ovf=0.
REQ-050 aresetn=0 while FULL mid-frame -> next cycle all outputs 0, no frame_done; after release a new frame counts from 0.
